led_pattern_seq: RTL
====================

// Module: led_pattern_seq
// PURPOSE
// - Parametrised LED pattern sequencer; successor to the fixed 8-LED switch-driven pattern block.
// - Four switches select one of four patterns: N-shot blink, continuous blink, alternate, walking-one.
// - Patterns advance on an internal tick divided from the board clock. The block drives the LED bank directly.
// - Adds a reset, switch synchronisation, clean restart on mode change, and status outputs.
// PARAMETERS
// - N_LED      8           LED count (o_led width), >= 2
// - TICK_DIV   50_000_000  clocks per pattern step, >= 2; counter width $clog2(TICK_DIV)
// - BLINK_CNT  3           toggles in N-shot blink mode, >= 1
// PORTS
// - i_clk    in   1      system clock, all logic posedge
// - i_rst    in   1      synchronous reset, active-high
// - i_sw     in   4      mode switches, asynchronous, one-hot select
// - o_led    out  N_LED  LED drive, registered
// - o_mode   out  3      current state encoding: 0 IDLE, 1 BLINKN, 2 BLINK, 3 ALT, 4 SHIFT, 5 DONE
// - o_done   out  1      high while in DONE (one-shot pattern finished)
// BEHAVIOUR
// - Reset (i_rst=1 at posedge): o_led=0, o_done=0, o_mode=0 (IDLE), tick cnt=0, step cnt=0, sync flops=0.
// - Reset has priority over everything, including mid-pattern; after reset the block re-decodes i_sw.
// - Switch path: 2-flop synchroniser -> sw_s. Desired mode from sw_s:
//   - 0001=BLINKN, 0010=BLINK, 0100=ALT, 1000=SHIFT
//   - any other value (0 or multi-hot) = IDLE
// - Mode change: when the desired mode differs from the mode last selected (DONE counts as its originating mode):
//   - enter the new state, tick cnt=0, step cnt=0, o_led=0, o_done=0, all on the same edge
//   - i_sw edge -> new state in o_mode after 3 clocks
// - Tick: tick cnt counts 0..TICK_DIV-1 and wraps. The step fires on the edge where cnt==TICK_DIV-1.
//   - First step lands TICK_DIV clocks after state entry. Tick cnt holds at 0 in IDLE and DONE.
// - IDLE: o_led=0, no steps.
// - BLINKN: each step o_led <= ~o_led, step cnt++.
//   - On the step where step cnt reaches BLINK_CNT: go to DONE, hold o_led, o_done=1.
// - BLINK: each step o_led <= ~o_led, forever.
// - ALT: first step o_led = 0101..01 (bit0=1); each later step o_led <= ~o_led.
// - SHIFT: step 1 sets o_led[0]=1; steps 2..N_LED shift left by 1.
//   - Step N_LED+1: o_led=0, go to DONE, o_done=1.
// - DONE: hold o_led, o_done=1. Leave only when the desired mode changes (incl. to IDLE) or on reset.
//   - Re-selecting the same switch therefore needs a pass through another value.
// - Simultaneous step and mode change: the mode change wins; the step is discarded.
// - All counters are unsigned, no saturation. Step cnt width $clog2(max(BLINK_CNT,N_LED)+2).
// CONFIGURATION
// - Macro LED_BOUNCE_EN.
// - Defined: SHIFT never goes to DONE. After the one reaches bit N_LED-1, steps shift right down to bit0, then left again, forever.
//   - Direction reverses on the step after reaching an end bit. o_done stays 0 in SHIFT.
// - Undefined: SHIFT is one-shot as above. No direction register is synthesised.
// TESTING (N_LED=8, TICK_DIV=4, BLINK_CNT=3)
// - i_sw=0001 -> o_mode=1 at clock 3; o_led FF,00,FF at steps 1-3; then DONE, o_led=FF held, o_done=1.
// - i_sw=0100 -> o_led 00, then 55,AA,55,AA every 4 clocks.
// - i_sw=1000 -> o_led 01,02,04,..,80, then 00 with o_done=1; hold 20 clocks; o_led stays 00.
// - i_sw 0010->0011 -> 3 clocks later o_mode=0, o_led=00, no further toggles.
// - i_rst=1 for 1 clock mid-SHIFT (o_led=10) -> next edge o_led=00, o_mode=0.
//   - After release, with i_sw still 1000, SHIFT restarts from 01.
// - LED_BOUNCE_EN, i_sw=1000 -> 01,02,..,80,40,..,01,02..; o_done never asserts.

Source files
------------

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: N-shot blink, continuous blink, alternate and walking-one patterns
// stepped by a divided tick. Define LED_BOUNCE_EN to make the walking-one bounce forever.
module led_pattern_seq #(
   parameter int N_LED     = 8,
   parameter int TICK_DIV  = 50_000_000,
   parameter int BLINK_CNT = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [3:0]       i_sw,
   output logic [N_LED-1:0] o_led,
   output logic [2:0]       o_mode,
   output logic             o_done
);

   localparam int TW   = $clog2(TICK_DIV);
   localparam int SMAX = (BLINK_CNT > N_LED) ? BLINK_CNT : N_LED;
   localparam int SW   = $clog2(SMAX + 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BLINKN = 3'd1,
      S_BLINK  = 3'd2,
      S_ALT    = 3'd3,
      S_SHIFT  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   logic [3:0]       sw_meta_q, sw_s_q;
   state_t           state_q, state_d;
   state_t           sel_q, sel_d;
   state_t           want;
   logic [TW-1:0]    tick_q, tick_d;
   logic [SW-1:0]    step_q, step_d;
   logic [N_LED-1:0] led_q, led_d;
   logic [N_LED-1:0] alt_pat;
   logic             running;
`ifdef LED_BOUNCE_EN
   logic             dir_q, dir_d;   // 1 = moving towards the MSB
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_LED; gi++) begin : g_alt
         assign alt_pat[gi] = ((gi % 2) == 0);
      end
   endgenerate

   always_comb begin
      case (sw_s_q)
         4'b0001: want = S_BLINKN;
         4'b0010: want = S_BLINK;
         4'b0100: want = S_ALT;
         4'b1000: want = S_SHIFT;
         default: want = S_IDLE;
      endcase
   end

   assign running = (state_q == S_BLINKN) || (state_q == S_BLINK) ||
                    (state_q == S_ALT)    || (state_q == S_SHIFT);

   // sel_q remembers the originating mode, so DONE only exits on a real switch change
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tick_d  = tick_q;
      step_d  = step_q;
      led_d   = led_q;
`ifdef LED_BOUNCE_EN
      dir_d   = dir_q;
`endif
      if (want != sel_q) begin
         state_d = want;
         sel_d   = want;
         tick_d  = '0;
         step_d  = '0;
         led_d   = '0;
`ifdef LED_BOUNCE_EN
         dir_d   = 1'b1;
`endif
      end else if (running) begin
         if (tick_q == TW'(TICK_DIV - 1)) begin
            tick_d = '0;
            case (state_q)
               S_BLINKN: begin
                  led_d  = ~led_q;
                  step_d = step_q + SW'(1);
                  if (step_d == SW'(BLINK_CNT))
                     state_d = S_DONE;
               end
               S_BLINK: led_d = ~led_q;
               S_ALT: begin
                  if (step_q == '0) begin
                     led_d  = alt_pat;
                     step_d = SW'(1);
                  end else begin
                     led_d = ~led_q;
                  end
               end
               S_SHIFT: begin
`ifdef LED_BOUNCE_EN
                  if (step_q == '0) begin
                     led_d  = N_LED'(1);
                     step_d = SW'(1);
                     dir_d  = 1'b1;
                  end else if (dir_q) begin
                     if (led_q[N_LED-1]) begin
                        led_d = led_q >> 1;
                        dir_d = 1'b0;
                     end else begin
                        led_d = led_q << 1;
                     end
                  end else begin
                     if (led_q[0]) begin
                        led_d = led_q << 1;
                        dir_d = 1'b1;
                     end else begin
                        led_d = led_q >> 1;
                     end
                  end
`else
                  step_d = step_q + SW'(1);
                  if (step_q == SW'(N_LED)) begin
                     led_d   = '0;
                     state_d = S_DONE;
                  end else if (step_q == '0) begin
                     led_d = N_LED'(1);
                  end else begin
                     led_d = led_q << 1;
                  end
`endif
               end
               default: ;
            endcase
         end else begin
            tick_d = tick_q + TW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sw_meta_q <= '0;
         sw_s_q    <= '0;
         state_q   <= S_IDLE;
         sel_q     <= S_IDLE;
         tick_q    <= '0;
         step_q    <= '0;
         led_q     <= '0;
`ifdef LED_BOUNCE_EN
         dir_q     <= 1'b1;
`endif
      end else begin
         sw_meta_q <= i_sw;
         sw_s_q    <= sw_meta_q;
         state_q   <= state_d;
         sel_q     <= sel_d;
         tick_q    <= tick_d;
         step_q    <= step_d;
         led_q     <= led_d;
`ifdef LED_BOUNCE_EN
         dir_q     <= dir_d;
`endif
      end
   end

   assign o_led  = led_q;
   assign o_mode = state_q;
   assign o_done = (state_q == S_DONE);

endmodule
